// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: source indices and keyboard
// typematic state encoding.
package irq_pkg;

    localparam int unsigned NUM_IRQ   = 2;
    localparam int unsigned IRQ_TIMER = 0;
    localparam int unsigned IRQ_KB    = 1;

    typedef enum logic [2:0] {
        KB_IDLE   = 3'b001,
        KB_DELAY  = 3'b010,
        KB_REPEAT = 3'b100
    } kb_state_t;

endpackage

// File: rtl/kb_repeat.sv
// Typematic keyboard event generator: first press, initial delay, then periodic
// repeats, with the key code latched on every event.
module kb_repeat
    import irq_pkg::*;
#(
    parameter int unsigned DELAY_CYC  = 25000000,
    parameter int unsigned REPEAT_CYC = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ascii,
    output logic       kb_event,
    output logic [7:0] kb_char
);

    localparam int unsigned MAX_CYC = (DELAY_CYC > REPEAT_CYC) ? DELAY_CYC : REPEAT_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC);

    kb_state_t         state, state_next;
    logic [CW-1:0]     cnt, cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= KB_IDLE;
            cnt     <= '0;
            kb_char <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (kb_event) kb_char <= ascii;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        kb_event   = 1'b0;
        unique case (state)
            KB_IDLE: begin
                cnt_next = '0;
                if (ascii != 8'd0) begin
                    kb_event   = 1'b1;
                    state_next = KB_DELAY;
                end
            end
            KB_DELAY, KB_REPEAT: begin
                // Release beats a code change, which beats the interval timeout.
                if (ascii == 8'd0) begin
                    state_next = KB_IDLE;
                    cnt_next   = '0;
                end else if (ascii != kb_char) begin
                    kb_event   = 1'b1;
                    cnt_next   = '0;
                    state_next = KB_DELAY;
                end else if ((state == KB_DELAY  && cnt == CW'(DELAY_CYC - 1)) ||
                             (state == KB_REPEAT && cnt == CW'(REPEAT_CYC - 1))) begin
                    kb_event   = 1'b1;
                    cnt_next   = '0;
                    state_next = KB_REPEAT;
                end
            end
            default: begin
                state_next = KB_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: periodic timer plus typematic keyboard events, latched
// into pending/overrun, masked and arbitrated onto a registered one-hot request.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned TIMER_PERIOD = 50000000,
    parameter int unsigned KB_DELAY     = 25000000,
    parameter int unsigned KB_REPEAT    = 12500000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         ascii,
    input  logic               irq_en,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               clr_we,
    input  logic [NUM_IRQ-1:0] clr_wdata,
    output logic [NUM_IRQ-1:0] irq_pins,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] overrun,
    output logic [NUM_IRQ-1:0] mask,
    output logic [7:0]         kb_char
);

    localparam int unsigned TW = $clog2(TIMER_PERIOD);

    logic [TW-1:0]      tmr_cnt;
    logic               tick;
    logic               kb_event;
    logic [NUM_IRQ-1:0] ev, clr, req, gnt;

    assign tick = (tmr_cnt == TW'(TIMER_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tmr_cnt <= '0;
        else if (tick) tmr_cnt <= '0;
        else           tmr_cnt <= tmr_cnt + TW'(1);
    end

    kb_repeat #(
        .DELAY_CYC  (KB_DELAY),
        .REPEAT_CYC (KB_REPEAT)
    ) u_kb_repeat (
        .clk      (clk),
        .rst_n    (rst_n),
        .ascii    (ascii),
        .kb_event (kb_event),
        .kb_char  (kb_char)
    );

    always_comb begin
        ev             = '0;
        ev[IRQ_TIMER]  = tick;
        ev[IRQ_KB]     = kb_event;
        clr            = clr_we ? clr_wdata : '0;
        req            = pending & mask;
        // An asserted grant holds while still requested; otherwise pick the
        // lowest set bit (timer first).
        if ((irq_pins & req) != '0) gnt = irq_pins;
        else                        gnt = req & (~req + NUM_IRQ'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overrun  <= '0;
            mask     <= '1;
            irq_pins <= '0;
        end else begin
            pending  <= (pending & ~clr) | ev;
            overrun  <= (overrun & ~clr) | (ev & pending & ~clr);
            irq_pins <= irq_en ? gnt : '0;
            if (mask_we) mask <= mask_wdata;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations
// plus a randomized phase, all compared each cycle against a behavioural model.
module tb_irq_ctrl;

    localparam int unsigned TP = 8;
    localparam int unsigned KD = 6;
    localparam int unsigned KR = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ascii = 8'h00;
    logic       irq_en = 1'b0;
    logic       mask_we = 1'b0;
    logic [1:0] mask_wdata = 2'b00;
    logic       clr_we = 1'b0;
    logic [1:0] clr_wdata = 2'b00;
    logic [1:0] irq_pins, pending, overrun, mask;
    logic [7:0] kb_char;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .TIMER_PERIOD (TP),
        .KB_DELAY     (KD),
        .KB_REPEAT    (KR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ascii      (ascii),
        .irq_en     (irq_en),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .clr_we     (clr_we),
        .clr_wdata  (clr_wdata),
        .irq_pins   (irq_pins),
        .pending    (pending),
        .overrun    (overrun),
        .mask       (mask),
        .kb_char    (kb_char)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cycles since reset, key hold age, and per-bit rules.
    int unsigned m_cyc = 0;
    logic [1:0]  m_pend = 2'b00, m_ovr = 2'b00, m_mask = 2'b11, m_pins = 2'b00;
    logic [7:0]  m_char = 8'h00;
    bit          key_on = 1'b0;
    logic [7:0]  key_code = 8'h00;
    int unsigned key_age = 0;
    logic [1:0]  m_ev, m_clr, m_req, m_gnt;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cyc = 0; m_pend = 2'b00; m_ovr = 2'b00; m_mask = 2'b11;
            m_pins = 2'b00; m_char = 8'h00; key_on = 1'b0; key_code = 8'h00; key_age = 0;
        end else begin
            m_ev = 2'b00;
            m_cyc++;
            if (m_cyc % TP == 0) m_ev[0] = 1'b1;
            if (ascii == 8'h00) begin
                key_on = 1'b0;
            end else if (!key_on || ascii != key_code) begin
                key_on = 1'b1; key_code = ascii; key_age = 0; m_ev[1] = 1'b1;
            end else begin
                key_age++;
                if (key_age == KD || (key_age > KD && (key_age - KD) % KR == 0)) m_ev[1] = 1'b1;
            end
            if (m_ev[1]) m_char = ascii;
            m_req = m_pend & m_mask;
            if ((m_pins & m_req) != 2'b00) m_gnt = m_pins;
            else if (m_req[0])             m_gnt = 2'b01;
            else if (m_req[1])             m_gnt = 2'b10;
            else                           m_gnt = 2'b00;
            m_pins = irq_en ? m_gnt : 2'b00;
            m_clr = clr_we ? clr_wdata : 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (m_clr[i])                  m_ovr[i] = 1'b0;
                else if (m_ev[i] && m_pend[i]) m_ovr[i] = 1'b1;
                if (m_ev[i])                   m_pend[i] = 1'b1;
                else if (m_clr[i])             m_pend[i] = 1'b0;
            end
            if (mask_we) m_mask = mask_wdata;
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_on) begin
            chk("irq_pins", irq_pins, m_pins);
            chk("pending",  pending,  m_pend);
            chk("overrun",  overrun,  m_ovr);
            chk("mask",     mask,     m_mask);
            chk("kb_char",  kb_char,  m_char);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_phase(input int unsigned ph);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2 * TP && !ok; k++) begin
            if (m_cyc % TP == ph) ok = 1'b1;
            else step(1);
        end
        chk("phase_sync", 8'(ok), 8'd1);
    endtask

    int unsigned ev_at[6] = '{1, 7, 10, 13, 16, 19};

    initial begin
        bit exp_ev;

        // Timer tick
        irq_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_on = 1'b1;
        chk("rst_mask", mask, 8'h03);
        step(7);  chk("t_pend_c7", pending, 8'h00);
        step(1);  chk("t_pend_c8", pending, 8'h01); chk("t_pins_c8", irq_pins, 8'h00);
        step(1);  chk("t_pins_c9", irq_pins, 8'h01);
        clr_we = 1'b1; clr_wdata = 2'b01;
        step(1);  clr_we = 1'b0;
        chk("t_clr_pend", pending, 8'h00); chk("t_pins_hold", irq_pins, 8'h01);
        step(1);  chk("t_pins_drop", irq_pins, 8'h00);
        step(4);  chk("t_pend_c15", pending, 8'h00);
        step(1);  chk("t_pend_c16", pending, 8'h01);

        // Typematic with timer masked
        mask_we = 1'b1; mask_wdata = 2'b10; clr_we = 1'b1; clr_wdata = 2'b11;
        step(1);
        mask_we = 1'b0; clr_we = 1'b0;
        ascii = 8'h41;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            clr_we = 1'b0;
            exp_ev = 1'b0;
            foreach (ev_at[j]) if (ev_at[j] == i) exp_ev = 1'b1;
            chk($sformatf("kb_ev_%0d", i), 8'(pending[1]), 8'(exp_ev));
            if (exp_ev) chk($sformatf("kb_chr_%0d", i), kb_char, 8'h41);
            if (pending[1]) begin clr_we = 1'b1; clr_wdata = 2'b10; end
        end
        ascii = 8'h00;
        clr_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("kb_release", 8'(pending[1]), 8'd0);
        end

        // Key change and overrun
        clr_we = 1'b1; clr_wdata = 2'b11;
        step(1);
        clr_we = 1'b0;
        ascii = 8'h41;
        step(1);  chk("kc_first", 8'(pending[1]), 8'd1); chk("kc_ovr0", 8'(overrun[1]), 8'd0);
        step(2);  ascii = 8'h42;
        step(1);  chk("kc_char", kb_char, 8'h42); chk("kc_ovr", 8'(overrun[1]), 8'd1);
        clr_we = 1'b1; clr_wdata = 2'b10;
        step(1);  clr_we = 1'b0; chk("kc_ovr_clr", 8'(overrun[1]), 8'd0);
        step(4);  chk("kc_rep_pre", 8'(pending[1]), 8'd0);
        step(1);  chk("kc_rep", 8'(pending[1]), 8'd1); chk("kc_rep_chr", kb_char, 8'h42);
        ascii = 8'h00; clr_we = 1'b1; clr_wdata = 2'b10;
        step(1);
        clr_we = 1'b0;

        // Priority and gating
        irq_en = 1'b0; mask_we = 1'b1; mask_wdata = 2'b11;
        step(1);
        mask_we = 1'b0;
        wait_phase(2);
        clr_we = 1'b1; clr_wdata = 2'b11; ascii = 8'h43;
        step(1);
        clr_we = 1'b0; ascii = 8'h00;
        step(5);  chk("pr_both", pending, 8'h03); chk("pr_gated0", irq_pins, 8'h00);
        step(1);  chk("pr_gated1", irq_pins, 8'h00);
        irq_en = 1'b1;
        step(1);  chk("pr_timer", irq_pins, 8'h01);
        clr_we = 1'b1; clr_wdata = 2'b01;
        step(1);  clr_we = 1'b0; chk("pr_pend_kb", pending, 8'h02); chk("pr_lag", irq_pins, 8'h01);
        step(1);  chk("pr_kb", irq_pins, 8'h02);
        mask_we = 1'b1; mask_wdata = 2'b01;
        step(1);  mask_we = 1'b0; chk("pr_mask", mask, 8'h01);
        step(1);  chk("pr_masked", irq_pins, 8'h00); chk("pr_keep", pending, 8'h02);

        // Set/clear collision on the timer bit
        mask_we = 1'b1; mask_wdata = 2'b11;
        step(1);
        mask_we = 1'b0;
        wait_phase(1);
        clr_we = 1'b1; clr_wdata = 2'b11;
        step(1);
        clr_we = 1'b0;
        step(6);  chk("co_tick", 8'(pending[0]), 8'd1); chk("co_ovr_pre", 8'(overrun[0]), 8'd0);
        step(7);
        clr_we = 1'b1; clr_wdata = 2'b01;
        step(1);  clr_we = 1'b0;
        chk("co_set_wins", 8'(pending[0]), 8'd1); chk("co_no_ovr", 8'(overrun[0]), 8'd0);
        step(8);  chk("co_ovr", 8'(overrun[0]), 8'd1);

        // Async reset in the middle of the keyboard delay
        clr_we = 1'b1; clr_wdata = 2'b11;
        step(1);
        clr_we = 1'b0;
        ascii = 8'h44;
        step(3);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_pins", irq_pins, 8'h00); chk("ar_pend", pending, 8'h00);
        chk("ar_ovr", overrun, 8'h00);   chk("ar_mask", mask, 8'h03);
        chk("ar_char", kb_char, 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1);  chk("ar_fresh", pending, 8'h02); chk("ar_fresh_chr", kb_char, 8'h44);

        // Randomized phase
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: ascii = 8'h00;
                    1: ascii = 8'h41;
                    2: ascii = 8'h42;
                    default: ascii = 8'h5a;
                endcase
            end
            irq_en     = ($urandom_range(0, 7) != 0);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 2'($urandom_range(0, 3));
            clr_we     = ($urandom_range(0, 3) == 0);
            clr_wdata  = 2'($urandom_range(0, 3));
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
